// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled start/data/parity/stop decoding with
// a two-flop input synchroniser, per-frame parity/framing flags and a
// valid/ready output register with overrun reporting.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 32,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   LAST_CYC  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_CYC  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]      LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]      LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic            ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Synchroniser and edge-detect state
    logic       r_sync1;
    logic       r_rx_s;
    logic       r_rx_prev;
    logic [1:0] r_fill;
    logic       r_armed;
    logic       w_start_edge;

    // Frame decoder state
    state_t                r_state,   w_state_next;
    logic [CW-1:0]         r_cyc,     w_cyc_next;
    logic [3:0]            r_bit,     w_bit_next;
    logic [DATA_BITS-1:0]  r_shift,   w_shift_next;
    logic                  r_par_err, w_par_err_next;
    logic                  r_frm_err, w_frm_err_next;
    logic                  r_done,    w_done_next;

    // Output register
    logic [DATA_BITS-1:0]  r_data;
    logic                  r_data_valid;
    logic                  r_parity_err;
    logic                  r_frame_err;
    logic                  r_overrun;
    logic                  w_accept;

    // Two-flop synchroniser plus one-cycle delay for falling-edge detection.
    // r_fill tracks when the synchroniser holds real line samples again after
    // reset; r_armed only rises once the line has been seen high, so a line
    // held low through reset cannot fake a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
            r_fill    <= 2'b00;
            r_armed   <= 1'b0;
        end else begin
            r_sync1   <= rx;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
            r_fill    <= {r_fill[0], 1'b1};
            if (r_fill[1] && r_rx_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_start_edge = r_armed & r_rx_prev & ~r_rx_s;

    // Decoder state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cyc     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cyc     <= w_cyc_next;
            r_bit     <= w_bit_next;
            r_shift   <= w_shift_next;
            r_par_err <= w_par_err_next;
            r_frm_err <= w_frm_err_next;
            r_done    <= w_done_next;
        end
    end

    // Next-state logic: mid-bit sampling of start, data, parity and stop bits
    always_comb begin
        w_state_next   = r_state;
        w_cyc_next     = r_cyc;
        w_bit_next     = r_bit;
        w_shift_next   = r_shift;
        w_par_err_next = r_par_err;
        w_frm_err_next = r_frm_err;
        w_done_next    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_state_next   = S_START;
                    w_cyc_next     = '0;
                    w_bit_next     = '0;
                    w_par_err_next = 1'b0;
                    w_frm_err_next = 1'b0;
                end
            end
            S_START: begin
                if (r_cyc == HALF_CYC) begin
                    w_cyc_next   = '0;
                    // A line back high at mid start bit is a glitch, not a frame
                    w_state_next = r_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_cyc_next = r_cyc + 1'b1;
                end
            end
            S_DATA: begin
                if (r_cyc == LAST_CYC) begin
                    w_cyc_next   = '0;
                    // Shift in from the top so the first bit ends up in bit 0
                    w_shift_next = {r_rx_s, r_shift[DATA_BITS-1:1]};
                    if (r_bit == LAST_DATA) begin
                        w_bit_next   = '0;
                        w_state_next = (PARITY == 0) ? S_STOP : S_PARITY;
                    end else begin
                        w_bit_next = r_bit + 1'b1;
                    end
                end else begin
                    w_cyc_next = r_cyc + 1'b1;
                end
            end
            S_PARITY: begin
                if (r_cyc == LAST_CYC) begin
                    w_cyc_next     = '0;
                    w_par_err_next = ((^r_shift) ^ r_rx_s) != ODD_PAR;
                    w_state_next   = S_STOP;
                end else begin
                    w_cyc_next = r_cyc + 1'b1;
                end
            end
            S_STOP: begin
                if (r_cyc == LAST_CYC) begin
                    w_cyc_next = '0;
                    if (!r_rx_s) begin
                        w_frm_err_next = 1'b1;
                    end
                    if (r_bit == LAST_STOP) begin
                        // Return to IDLE at the last stop sample so a
                        // back-to-back start edge half a bit later is caught
                        w_bit_next   = '0;
                        w_state_next = S_IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_bit_next = r_bit + 1'b1;
                    end
                end else begin
                    w_cyc_next = r_cyc + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_accept = r_data_valid & data_ready;

    // Output holding register: load a finished frame, or flag overrun when the
    // previous word is still waiting and is not being accepted this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (r_done && (!r_data_valid || w_accept)) begin
            r_data       <= r_shift;
            r_parity_err <= r_par_err;
            r_frame_err  <= r_frm_err;
            r_data_valid <= 1'b1;
            r_overrun    <= 1'b0;
        end else if (r_done) begin
            r_overrun <= 1'b1;
        end else if (w_accept) begin
            r_data_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end
    end

    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: a default-configured receiver (8E1, 32 clk/bit) and
// a 7N2, 16 clk/bit receiver, driven with directed and random serial frames.
module tb_uart_rx_param;

    localparam int CPB_A = 32;
    localparam int CPB_B = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic       rdy_a = 1'b0;
    logic       rdy_b = 1'b0;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       valid_a, pe_a, fe_a, ovr_a;
    logic       valid_b, pe_b, fe_b, ovr_b;

    int total = 0;
    int bad   = 0;

    // model of the A receiver's output register
    logic [7:0] m_data;
    logic       m_valid, m_pe, m_fe, m_ovr;

    always #5 clk = ~clk;

    uart_rx_param dut_a (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx_a),
        .data       (data_a),
        .data_valid (valid_a),
        .data_ready (rdy_a),
        .parity_err (pe_a),
        .frame_err  (fe_a),
        .overrun    (ovr_a)
    );

    uart_rx_param #(
        .CLKS_PER_BIT (CPB_B),
        .DATA_BITS    (7),
        .PARITY       (0),
        .STOP_BITS    (2)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx_b),
        .data       (data_b),
        .data_valid (valid_b),
        .data_ready (rdy_b),
        .parity_err (pe_b),
        .frame_err  (fe_b),
        .overrun    (ovr_b)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [7:0] d, input logic v,
                           input logic pe, input logic fe, input logic ov);
        check({tag, ".data"}, 16'(data_a), 16'(d));
        check({tag, ".valid"}, 16'(valid_a), 16'(v));
        check({tag, ".perr"}, 16'(pe_a), 16'(pe));
        check({tag, ".ferr"}, 16'(fe_a), 16'(fe));
        check({tag, ".ovr"}, 16'(ovr_a), 16'(ov));
        $display("%s: data=0x%02h valid=%0b perr=%0b ferr=%0b ovr=%0b", tag, data_a, valid_a, pe_a, fe_a, ovr_a);
    endtask

    task automatic check_b(input string tag, input logic [6:0] d, input logic v,
                           input logic pe, input logic fe);
        check({tag, ".data"}, 16'(data_b), 16'(d));
        check({tag, ".valid"}, 16'(valid_b), 16'(v));
        check({tag, ".perr"}, 16'(pe_b), 16'(pe));
        check({tag, ".ferr"}, 16'(fe_b), 16'(fe));
        $display("%s: data=0x%02h valid=%0b perr=%0b ferr=%0b", tag, data_b, valid_b, pe_b, fe_b);
    endtask

    // Serialise a frame: start bit, data LSB first, optional parity (even or
    // odd, optionally inverted), then stop bits taken from 'stops' bit 0 first.
    // Only the first 'upto' bits are sent; every bit lasts one bit period.
    task automatic send_frame(input bit sel, input logic [8:0] d, input int dbits,
                              input int pmode, input bit pflip, input logic [1:0] stops,
                              input int nstop, input int upto);
        logic bits [0:15];
        int   n;
        int   cpb;
        logic p;
        cpb = sel ? CPB_B : CPB_A;
        n = 0;
        bits[n] = 1'b0;
        n = n + 1;
        for (int i = 0; i < dbits; i++) begin
            bits[n] = d[i];
            n = n + 1;
        end
        if (pmode != 0) begin
            p = 1'b0;
            for (int i = 0; i < dbits; i++) p = p ^ d[i];
            if (pmode == 2) p = ~p;
            bits[n] = p ^ pflip;
            n = n + 1;
        end
        for (int i = 0; i < nstop; i++) begin
            bits[n] = stops[i];
            n = n + 1;
        end
        for (int i = 0; i < n && i < upto; i++) begin
            if (sel) rx_b = bits[i];
            else     rx_a = bits[i];
            repeat (cpb) @(negedge clk);
        end
    endtask

    task automatic idle(input bit sel, input int nbits);
        if (sel) rx_b = 1'b1;
        else     rx_a = 1'b1;
        repeat (nbits * (sel ? CPB_B : CPB_A)) @(negedge clk);
    endtask

    task automatic accept_a(input string tag);
        @(negedge clk) rdy_a = 1'b1;
        @(negedge clk) rdy_a = 1'b0;
        check({tag, ".acc_valid"}, 16'(valid_a), 16'd0);
        check({tag, ".acc_ovr"}, 16'(ovr_a), 16'd0);
    endtask

    task automatic accept_b(input string tag);
        @(negedge clk) rdy_b = 1'b1;
        @(negedge clk) rdy_b = 1'b0;
        check({tag, ".acc_valid"}, 16'(valid_b), 16'd0);
    endtask

    initial begin
        logic [7:0] rd;
        bit         rflip, rstop, racc;
        logic [1:0] stops;

        // reset state
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_a("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check_b("reset_b", 7'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        idle(0, 2);

        // good 0xE5 frame, even parity bit 1, one stop bit
        send_frame(0, 9'h0E5, 8, 1, 1'b0, 2'b11, 1, 99);
        check_a("t1_e5", 8'hE5, 1'b1, 1'b0, 1'b0, 1'b0);
        accept_a("t1");
        idle(0, 2);

        // bad parity, then bad stop bit
        send_frame(0, 9'h0E5, 8, 1, 1'b1, 2'b11, 1, 99);
        check_a("t2_par", 8'hE5, 1'b1, 1'b1, 1'b0, 1'b0);
        accept_a("t2a");
        idle(0, 2);
        send_frame(0, 9'h0E5, 8, 1, 1'b0, 2'b00, 1, 99);
        check_a("t2_stop", 8'hE5, 1'b1, 1'b0, 1'b1, 1'b0);
        accept_a("t2b");
        idle(0, 2);

        // glitch of 8 cycles is rejected, following frame is fine
        rx_a = 1'b0;
        repeat (8) @(negedge clk);
        rx_a = 1'b1;
        repeat (3 * CPB_A) @(negedge clk);
        check("t3_glitch.valid", 16'(valid_a), 16'd0);
        send_frame(0, 9'h03C, 8, 1, 1'b0, 2'b11, 1, 99);
        check_a("t3_3c", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        accept_a("t3");
        idle(0, 2);

        // back-to-back frames without accept -> overrun, first word kept
        send_frame(0, 9'h055, 8, 1, 1'b0, 2'b11, 1, 99);
        send_frame(0, 9'h0A3, 8, 1, 1'b0, 2'b11, 1, 99);
        check_a("t4_ovr", 8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
        accept_a("t4");
        idle(0, 2);

        // reset during data bit 3 of a frame while a word is held
        send_frame(0, 9'h077, 8, 1, 1'b0, 2'b11, 1, 99);
        idle(0, 2);
        send_frame(0, 9'h081, 8, 1, 1'b0, 2'b11, 1, 4);
        rx_a = 1'b0;
        repeat (CPB_A / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_a("t5_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        idle(0, 12);
        check("t5_abandon.valid", 16'(valid_a), 16'd0);
        send_frame(0, 9'h081, 8, 1, 1'b0, 2'b11, 1, 99);
        check_a("t5_81", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
        accept_a("t5");
        idle(0, 2);

        // line held low across reset release never starts a frame
        rx_a = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (15 * CPB_A) @(negedge clk);
        check("t5_low.valid", 16'(valid_a), 16'd0);
        idle(0, 2);
        check("t5_low_high.valid", 16'(valid_a), 16'd0);
        send_frame(0, 9'h0C3, 8, 1, 1'b0, 2'b11, 1, 99);
        check_a("t5_c3", 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
        accept_a("t5b");
        idle(0, 2);

        // random frames against the output-register model
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_data  = 8'hC3;
        m_pe    = 1'b0;
        m_fe    = 1'b0;
        for (int k = 0; k < 24; k++) begin
            rd    = 8'($urandom_range(0, 255));
            rflip = ($urandom_range(0, 3) == 0);
            rstop = ($urandom_range(0, 3) == 0);
            racc  = ($urandom_range(0, 2) != 0);
            send_frame(0, {1'b0, rd}, 8, 1, rflip, rstop ? 2'b00 : 2'b11, 1, 99);
            if (!m_valid) begin
                m_data  = rd;
                m_pe    = rflip;
                m_fe    = rstop;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
            check_a($sformatf("rnd%0d", k), m_data, m_valid, m_pe, m_fe, m_ovr);
            if (racc) begin
                accept_a($sformatf("rnd%0d", k));
                m_valid = 1'b0;
                m_ovr   = 1'b0;
                check($sformatf("rnd%0d.held", k), 16'(data_a), 16'(m_data));
            end
            idle(0, 2);
        end

        // 7N2 receiver at 16 clocks per bit
        idle(1, 2);
        send_frame(1, 9'h05A, 7, 0, 1'b0, 2'b11, 2, 99);
        check_b("t6_5a", 7'h5A, 1'b1, 1'b0, 1'b0);
        accept_b("t6a");
        idle(1, 2);
        send_frame(1, 9'h05A, 7, 0, 1'b0, 2'b01, 2, 99);
        check_b("t6_stop2", 7'h5A, 1'b1, 1'b0, 1'b1);
        accept_b("t6b");
        idle(1, 2);
        send_frame(1, 9'h05A, 7, 0, 1'b0, 2'b10, 2, 99);
        check_b("t6_stop1", 7'h5A, 1'b1, 1'b0, 1'b1);
        accept_b("t6c");
        idle(1, 2);
        for (int k = 0; k < 8; k++) begin
            rd    = 8'($urandom_range(0, 127));
            stops = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) stops = 2'b11;
            send_frame(1, {1'b0, rd}, 7, 0, 1'b0, stops, 2, 99);
            check_b($sformatf("rndb%0d", k), rd[6:0], 1'b1, 1'b0, (stops != 2'b11));
            accept_b($sformatf("rndb%0d", k));
            idle(1, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
